// File: rtl/kamus_csr_file.sv
// Machine-mode CSR file: storage, CSRRW/RS/RC commit, 64-bit cycle/instret/timecmp
// counters, trap/mret bookkeeping and interrupt request generation.
module kamus_csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] csr_addr_i,
    output logic [31:0] csr_rdata_o,
    input  logic        csr_we_i,
    input  logic [1:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_illegal_o,
    input  logic        retire_i,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_val_i,
    input  logic        mret_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending_o,
    output logic [31:0] irq_cause_o
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_TCMP     = 12'h7C0;
    localparam logic [11:0] A_TCMPH    = 12'h7C1;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] cycles, instret, timecmp;
    logic [63:0] cycles_n, instret_n;

    logic        mtip;
    logic [31:0] mip, pend;
    logic        mapped, read_only, wr_intent, do_write;
    logic [31:0] wval;

    assign mtip = (cycles >= timecmp);
    assign mip  = {20'b0, irq_ext_i, 3'b0, mtip, 3'b0, irq_sw_i, 3'b0};

    always_comb begin
        csr_rdata_o = 32'h0;
        mapped      = 1'b1;
        unique case (csr_addr_i)
            A_MSTATUS:            csr_rdata_o = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            A_MISA:               csr_rdata_o = MISA_VALUE;
            A_MIE:                csr_rdata_o = mie_q;
            A_MTVEC:              csr_rdata_o = mtvec_q;
            A_MSCRATCH:           csr_rdata_o = mscratch_q;
            A_MEPC:               csr_rdata_o = mepc_q;
            A_MCAUSE:             csr_rdata_o = mcause_q;
            A_MTVAL:              csr_rdata_o = mtval_q;
            A_MIP:                csr_rdata_o = mip;
            A_MCYCLE,  12'hC00,
            12'hC01:              csr_rdata_o = cycles[31:0];
            A_MCYCLEH, 12'hC80,
            12'hC81:              csr_rdata_o = cycles[63:32];
            A_MINSTR,  12'hC02:   csr_rdata_o = instret[31:0];
            A_MINSTRH, 12'hC82:   csr_rdata_o = instret[63:32];
            A_TCMP:               csr_rdata_o = timecmp[31:0];
            A_TCMPH:              csr_rdata_o = timecmp[63:32];
            12'hF11, 12'hF12,
            12'hF13:              csr_rdata_o = 32'h0;
            12'hF14:              csr_rdata_o = HART_ID;
            default:              mapped = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it may target read-only space.
    assign read_only     = (csr_addr_i[11:10] == 2'b11);
    assign wr_intent     = (csr_op_i == OP_RW) || (csr_op_i != 2'b00 && csr_wdata_i != 32'h0);
    assign csr_illegal_o = csr_we_i && (!mapped || (read_only && wr_intent));
    assign do_write      = csr_we_i && !csr_illegal_o && csr_op_i != 2'b00 && !trap_i && !mret_i;

    always_comb begin
        unique case (csr_op_i)
            OP_RS:   wval = csr_rdata_o | csr_wdata_i;
            OP_RC:   wval = csr_rdata_o & ~csr_wdata_i;
            default: wval = csr_wdata_i;
        endcase
    end

    // A written half takes the write data; the other half keeps the carry from the old value.
    always_comb begin
        cycles_n  = cycles + 64'd1;
        instret_n = instret + {63'b0, retire_i};
        if (do_write && csr_addr_i == A_MCYCLE)  cycles_n[31:0]   = wval;
        if (do_write && csr_addr_i == A_MCYCLEH) cycles_n[63:32]  = wval;
        if (do_write && csr_addr_i == A_MINSTR)  instret_n[31:0]  = wval;
        if (do_write && csr_addr_i == A_MINSTRH) instret_n[63:32] = wval;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles  <= 64'h0;
            instret <= 64'h0;
        end else begin
            cycles  <= cycles_n;
            instret <= instret_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= 32'h0;
            mtvec_q      <= RESET_MTVEC & ~32'h3;
            mscratch_q   <= 32'h0;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            mtval_q      <= 32'h0;
            timecmp      <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (trap_i) begin
            mepc_q       <= trap_pc_i & ~32'h3;
            mcause_q     <= trap_cause_i;
            mtval_q      <= trap_val_i;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_i) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (do_write) begin
            unique case (csr_addr_i)
                A_MSTATUS: begin
                    mstatus_mie  <= wval[3];
                    mstatus_mpie <= wval[7];
                end
                A_MIE:      mie_q          <= wval & MIE_MASK;
                A_MTVEC:    mtvec_q        <= wval & ~32'h3;
                A_MSCRATCH: mscratch_q     <= wval;
                A_MEPC:     mepc_q         <= wval & ~32'h3;
                A_MCAUSE:   mcause_q       <= wval;
                A_MTVAL:    mtval_q        <= wval;
                A_TCMP:     timecmp[31:0]  <= wval;
                A_TCMPH:    timecmp[63:32] <= wval;
                default: ;
            endcase
        end
    end

    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign pend          = mip & mie_q;
    assign irq_pending_o = mstatus_mie && (pend != 32'h0);

    always_comb begin
        irq_cause_o = 32'h8000_0000;
        if (pend[11])     irq_cause_o = 32'h8000_000B;
        else if (pend[3]) irq_cause_o = 32'h8000_0003;
        else if (pend[7]) irq_cause_o = 32'h8000_0007;
    end

endmodule
